// File: rtl/apb_slave_responder_if.sv
// APB3 bus bundle between an initiator under test and the responder model.
// Clock and reset stay outside the bundle as plain ports.
interface apb_slave_responder_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_responder.sv
// APB3 completer model: word memory, programmable wait states, address-based
// error injection, saturating transfer counters and a sticky protocol-violation flag.
module apb_slave_responder #(
    parameter int unsigned MEM_AW = 8,
    parameter int unsigned TPD    = 1
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_slave_responder_if.slave apb,
    input  logic [3:0]           WAIT_CYCLES,
    input  logic                 ERR_EN,
    input  logic [31:0]          ERR_ADDR,
    output logic [15:0]          WR_CNT,
    output logic [15:0]          RD_CNT,
    output logic [15:0]          ERR_CNT,
    output logic                 PROT_ERR
);
    localparam int unsigned DEPTH = 1 << MEM_AW;
    // TPD only matters to timed behavioural wrappers; this netlist carries no delay.
    localparam int unsigned unused_tpd = TPD;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    state_e             state_q;
    logic [3:0]         wcnt_q;
    logic [31:0]        addr_q;
    logic               write_q;
    logic [31:0]        wdata_q;
    logic               err_q;
    logic [31:0]        rdata_q;
    logic [15:0]        wr_cnt_q;
    logic [15:0]        rd_cnt_q;
    logic [15:0]        err_cnt_q;
    logic               prot_err_q;
    logic [31:0]        mem_q [0:DEPTH-1];

    logic               setup_s;
    logic               bad_sel_s;
    logic               viol_s;
    logic               done_s;
    logic               ready_s;
    logic [MEM_AW-1:0]  idx_s;
    logic [MEM_AW-1:0]  idx_q;
    logic               unused_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 16'd1;
        end
    endfunction

    function automatic logic addr_err(input logic [31:0] paddr, input logic en,
                                      input logic [29:0] err_word);
        addr_err = (paddr[1:0] != 2'b00) | (en & (paddr[31:2] == err_word));
    endfunction

    assign idx_s    = apb.PADDR[MEM_AW+1:2];
    assign idx_q    = addr_q[MEM_AW+1:2];
    assign unused_s = ^ERR_ADDR[1:0];

    assign WR_CNT   = wr_cnt_q;
    assign RD_CNT   = rd_cnt_q;
    assign ERR_CNT  = err_cnt_q;
    assign PROT_ERR = prot_err_q;

    // Bus phase decode; any change of the captured request during ACCESS is a violation.
    always_comb begin
        setup_s   = 1'b0;
        bad_sel_s = 1'b0;
        viol_s    = 1'b0;
        done_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                setup_s   = apb.PSEL & ~apb.PENABLE;
                bad_sel_s = apb.PSEL &  apb.PENABLE;
            end
            ST_ACCESS: begin
                viol_s = ~apb.PSEL | ~apb.PENABLE
                       | (apb.PADDR  != addr_q)
                       | (apb.PWRITE != write_q)
                       | (apb.PWDATA != wdata_q);
                done_s = ~viol_s & (wcnt_q == 4'd0);
            end
            default: begin
                setup_s = 1'b0;
            end
        endcase
    end

    // Response outputs; reset forces the handshake low even mid-completion.
    always_comb begin
        ready_s     = done_s & ~PRESET;
        apb.PREADY  = ready_s;
        apb.PSLVERR = ready_s & err_q;
        if (ready_s & ~write_q & ~err_q) begin
            apb.PRDATA = rdata_q;
        end else begin
            apb.PRDATA = 32'h0000_0000;
        end
    end

    // Transfer FSM with request capture, counters and the sticky violation flag.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= 4'd0;
            addr_q     <= 32'h0000_0000;
            write_q    <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            wr_cnt_q   <= 16'd0;
            rd_cnt_q   <= 16'd0;
            err_cnt_q  <= 16'd0;
            prot_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (setup_s) begin
                        addr_q  <= apb.PADDR;
                        write_q <= apb.PWRITE;
                        wdata_q <= apb.PWDATA;
                        wcnt_q  <= WAIT_CYCLES;
                        rdata_q <= mem_q[idx_s];
                        err_q   <= addr_err(apb.PADDR, ERR_EN, ERR_ADDR[31:2]);
                        state_q <= ST_ACCESS;
                    end else if (bad_sel_s) begin
                        prot_err_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (viol_s) begin
                        prot_err_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else if (wcnt_q != 4'd0) begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end else begin
                        if (write_q) begin
                            wr_cnt_q <= sat_inc(wr_cnt_q);
                        end else begin
                            rd_cnt_q <= sat_inc(rd_cnt_q);
                        end
                        if (err_q) begin
                            err_cnt_q <= sat_inc(err_cnt_q);
                        end
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory commit at the completion edge; contents deliberately survive reset.
    always_ff @(posedge PCLK) begin
        if (done_s && !PRESET && write_q && !err_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end
endmodule
